// File: rtl/apple_spawn_ctrl.sv
// Apple placement: draws folded LFSR candidates, scans the snake body for collisions, commits a free cell.
// Latency: length+4 cycles from eaten to a visible apple when no candidate hits; eaten is dropped while busy.
module apple_spawn_ctrl #(
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int H_LOGIC_MAX   = 31,
    parameter int V_LOGIC_MAX   = 23,
    parameter int LEN_WIDTH     = 10,
    parameter int MAX_TRIES     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     eaten,
    input  logic [H_LOGIC_WIDTH-1:0] rand_x,
    input  logic [V_LOGIC_WIDTH-1:0] rand_y,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic [LEN_WIDTH-1:0]     seg_addr,
    input  logic [H_LOGIC_WIDTH-1:0] seg_x,
    input  logic [V_LOGIC_WIDTH-1:0] seg_y,
    output logic [H_LOGIC_WIDTH-1:0] apple_x,
    output logic [V_LOGIC_WIDTH-1:0] apple_y,
    output logic                     apple_valid,
    output logic                     busy,
    output logic                     spawn_done,
    output logic                     place_fail
);

    typedef enum logic [1:0] {IDLE, PICK, SCAN, COMMIT} state_t;

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]         TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [H_LOGIC_WIDTH-1:0] H_FOLD  = H_LOGIC_WIDTH'(H_LOGIC_MAX + 1);
    localparam logic [V_LOGIC_WIDTH-1:0] V_FOLD  = V_LOGIC_WIDTH'(V_LOGIC_MAX + 1);
    localparam logic [LEN_WIDTH-1:0]     LEN_ONE = LEN_WIDTH'(1);

    state_t                     state;
    state_t                     state_nxt;
    logic [H_LOGIC_WIDTH-1:0]   cand_x;
    logic [V_LOGIC_WIDTH-1:0]   cand_y;
    logic [H_LOGIC_WIDTH-1:0]   fold_x;
    logic [V_LOGIC_WIDTH-1:0]   fold_y;
    logic [TRY_W-1:0]           try_cnt;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [LEN_WIDTH-1:0]       scan_idx;
    logic                       issue_done;
    logic                       cmp_vld;
    logic                       cmp_last;
    logic                       hit;
    logic                       give_up;
    logic                       idx_last;

    always_comb begin
        fold_x = rand_x;
        fold_y = rand_y;
        if (int'(rand_x) > H_LOGIC_MAX) fold_x = rand_x - H_FOLD;
        if (int'(rand_y) > V_LOGIC_MAX) fold_y = rand_y - V_FOLD;
    end

    // cmp_vld marks that seg_x/seg_y carry a read issued last cycle
    assign hit      = cmp_vld && (seg_x == cand_x) && (seg_y == cand_y);
    assign give_up  = (try_cnt >= TRY_MAX);
    assign idx_last = (scan_idx == len_q - LEN_ONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (eaten) state_nxt = PICK;
            PICK:   state_nxt = (length == '0) ? COMMIT : SCAN;
            SCAN: begin
                if (hit)                      state_nxt = give_up ? COMMIT : PICK;
                else if (cmp_vld && cmp_last) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            apple_x    <= H_LOGIC_WIDTH'(15);
            apple_y    <= V_LOGIC_WIDTH'(15);
            cand_x     <= '0;
            cand_y     <= '0;
            try_cnt    <= '0;
            place_fail <= 1'b0;
            len_q      <= '0;
            scan_idx   <= '0;
            issue_done <= 1'b0;
            cmp_vld    <= 1'b0;
            cmp_last   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                PICK: begin
                    cand_x     <= fold_x;
                    cand_y     <= fold_y;
                    try_cnt    <= try_cnt + 1'b1;
                    len_q      <= length;
                    scan_idx   <= '0;
                    issue_done <= 1'b0;
                    cmp_vld    <= 1'b0;
                    cmp_last   <= 1'b0;
                    place_fail <= 1'b0;
                end
                SCAN: begin
                    if (state_nxt == SCAN) begin
                        cmp_vld  <= !issue_done;
                        cmp_last <= !issue_done && idx_last;
                        if (!issue_done) begin
                            if (idx_last) issue_done <= 1'b1;
                            else          scan_idx   <= scan_idx + LEN_ONE;
                        end
                    end else begin
                        // leaving SCAN drops any read still in flight
                        cmp_vld  <= 1'b0;
                        cmp_last <= 1'b0;
                        if (hit && give_up) place_fail <= 1'b1;
                    end
                end
                COMMIT: begin
                    apple_x <= cand_x;
                    apple_y <= cand_y;
                    try_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign apple_valid = (state == IDLE);
    assign busy        = (state != IDLE);
    assign spawn_done  = (state == COMMIT);
    assign seg_addr    = (state == SCAN) ? scan_idx : '0;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Directed bench for apple_spawn_ctrl with a synchronous-read body memory model.
module tb_apple_spawn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       eaten = 1'b0;
    logic [4:0] rand_x = '0;
    logic [4:0] rand_y = '0;
    logic [9:0] length = 10'd3;
    logic [9:0] seg_addr;
    logic [4:0] seg_x = '0;
    logic [4:0] seg_y = '0;
    logic [4:0] apple_x;
    logic [4:0] apple_y;
    logic       apple_valid;
    logic       busy;
    logic       spawn_done;
    logic       place_fail;

    logic [4:0] body_x [16];
    logic [4:0] body_y [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apple_spawn_ctrl dut (
        .clk(clk), .rst(rst), .eaten(eaten), .rand_x(rand_x), .rand_y(rand_y),
        .length(length), .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .busy(busy), .spawn_done(spawn_done), .place_fail(place_fail)
    );

    always @(posedge clk) begin
        seg_x <= body_x[seg_addr[3:0]];
        seg_y <= body_y[seg_addr[3:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ticks until spawn_done is seen; n = cycles waited, -1 on timeout
    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            eaten = 1'b0;
            if (spawn_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_checks++; if (apple_x !== 5'd15 || apple_y !== 5'd15) begin n_fail++; $display("FAIL reset_apple got (%0d,%0d) want (15,15)", apple_x, apple_y); end
        n_checks++; if (apple_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags valid=%b busy=%b want 1/0", apple_valid, busy); end
        n_checks++; if (spawn_done !== 1'b0 || place_fail !== 1'b0 || seg_addr !== 10'd0) begin n_fail++; $display("FAIL reset_misc done=%b fail=%b addr=%0d want 0/0/0", spawn_done, place_fail, seg_addr); end
    endtask

    task automatic test_spawn_basic();
        length = 10'd3;
        rand_x = 5'd10; rand_y = 5'd5;
        eaten = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            eaten = 1'b0;
            if (n == 1) begin
                n_checks++; if (busy !== 1'b1 || apple_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pick_flags busy=%b valid=%b want 1/0", busy, apple_valid); end
            end
            if (n >= 2 && n <= 4) begin
                n_checks++; if (seg_addr !== 10'(n - 2)) begin n_fail++; $display("FAIL basic_seg_addr cycle %0d got %0d want %0d", n, seg_addr, n - 2); end
            end
            if (n == 5) begin
                n_checks++; if (spawn_done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got %b want 0", spawn_done); end
            end
            if (n == 6) begin
                n_checks++; if (spawn_done !== 1'b1 || seg_addr !== 10'd0) begin n_fail++; $display("FAIL basic_commit done=%b addr=%0d want 1/0", spawn_done, seg_addr); end
            end
            if (n == 7) begin
                n_checks++; if (apple_x !== 5'd10 || apple_y !== 5'd5 || apple_valid !== 1'b1) begin n_fail++; $display("FAIL basic_apple got (%0d,%0d) v=%b want (10,5) v=1", apple_x, apple_y, apple_valid); end
                n_checks++; if (place_fail !== 1'b0 || spawn_done !== 1'b0) begin n_fail++; $display("FAIL basic_after fail=%b done=%b want 0/0", place_fail, spawn_done); end
            end
        end
    endtask

    task automatic test_fold();
        logic [4:0] rx [3] = '{5'd4, 5'd9, 5'd31};
        logic [4:0] ry [3] = '{5'd28, 5'd24, 5'd23};
        logic [4:0] ey [3] = '{5'd4, 5'd0, 5'd23};
        int n;
        for (int k = 0; k < 3; k++) begin
            rand_x = rx[k]; rand_y = ry[k];
            eaten = 1'b1;
            wait_done(20, n);
            n_checks++; if (n !== 6) begin n_fail++; $display("FAIL fold_latency case %0d got %0d want 6", k, n); end
            tick();
            n_checks++; if (apple_x !== rx[k] || apple_y !== ey[k]) begin n_fail++; $display("FAIL fold_apple case %0d got (%0d,%0d) want (%0d,%0d)", k, apple_x, apple_y, rx[k], ey[k]); end
        end
    endtask

    task automatic test_zero_length();
        int n;
        length = 10'd0;
        rand_x = 5'd6; rand_y = 5'd6;
        eaten = 1'b1;
        wait_done(20, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL zero_len_latency got %0d want 2", n); end
        tick();
        n_checks++; if (apple_x !== 5'd6 || apple_y !== 5'd6) begin n_fail++; $display("FAIL zero_len_apple got (%0d,%0d) want (6,6)", apple_x, apple_y); end
        length = 10'd3;
    endtask

    task automatic test_retry();
        int n;
        rand_x = 5'd2; rand_y = 5'd1;
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        tick();
        rand_x = 5'd7; rand_y = 5'd7;
        n_checks++; if (seg_addr !== 10'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL retry_scan_start addr=%0d busy=%b want 0/1", seg_addr, busy); end
        wait_done(40, n);
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL retry_latency got %0d want 8", n); end
        tick();
        n_checks++; if (apple_x !== 5'd7 || apple_y !== 5'd7 || place_fail !== 1'b0) begin n_fail++; $display("FAIL retry_apple got (%0d,%0d) fail=%b want (7,7) fail=0", apple_x, apple_y, place_fail); end
    endtask

    task automatic test_force_place();
        int n;
        rand_x = 5'd1; rand_y = 5'd1;
        eaten = 1'b1;
        wait_done(80, n);
        n_checks++; if (n !== 25) begin n_fail++; $display("FAIL force_latency got %0d want 25", n); end
        tick();
        n_checks++; if (apple_x !== 5'd1 || apple_y !== 5'd1 || place_fail !== 1'b1) begin n_fail++; $display("FAIL force_apple got (%0d,%0d) fail=%b want (1,1) fail=1", apple_x, apple_y, place_fail); end
        repeat (3) tick();
        n_checks++; if (place_fail !== 1'b1) begin n_fail++; $display("FAIL force_sticky got %b want 1", place_fail); end
        rand_x = 5'd10; rand_y = 5'd5;
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        tick();
        n_checks++; if (place_fail !== 1'b0) begin n_fail++; $display("FAIL force_clear got %b want 0", place_fail); end
        wait_done(20, n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL force_next_latency got %0d want 4", n); end
        tick();
        n_checks++; if (apple_x !== 5'd10 || apple_y !== 5'd5) begin n_fail++; $display("FAIL force_next_apple got (%0d,%0d) want (10,5)", apple_x, apple_y); end
    endtask

    task automatic test_reset_mid_scan();
        int seen = 0;
        rand_x = 5'd12; rand_y = 5'd12;
        eaten = 1'b1;
        tick();
        eaten = 1'b0;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b1 || seg_addr !== 10'd1) begin n_fail++; $display("FAIL midscan_pre busy=%b addr=%0d want 1/1", busy, seg_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || apple_valid !== 1'b1 || seg_addr !== 10'd0) begin n_fail++; $display("FAIL midscan_flags busy=%b valid=%b addr=%0d want 0/1/0", busy, apple_valid, seg_addr); end
        n_checks++; if (apple_x !== 5'd15 || apple_y !== 5'd15 || place_fail !== 1'b0) begin n_fail++; $display("FAIL midscan_apple got (%0d,%0d) fail=%b want (15,15) fail=0", apple_x, apple_y, place_fail); end
        for (int i = 0; i < 10; i++) begin
            if (spawn_done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midscan_no_done got %0d active cycles want 0", seen); end
    endtask

    task automatic test_eaten_while_busy();
        int busy_cycles = 0;
        rand_x = 5'd20; rand_y = 5'd10;
        eaten = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            eaten = (n == 2);
            if (n == 6) begin
                n_checks++; if (spawn_done !== 1'b1) begin n_fail++; $display("FAIL busy_eat_done got %b want 1", spawn_done); end
            end
        end
        eaten = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy !== 1'b0) busy_cycles++;
        end
        n_checks++; if (busy_cycles !== 0) begin n_fail++; $display("FAIL busy_eat_queued got %0d busy cycles want 0", busy_cycles); end
        n_checks++; if (apple_x !== 5'd20 || apple_y !== 5'd10) begin n_fail++; $display("FAIL busy_eat_apple got (%0d,%0d) want (20,10)", apple_x, apple_y); end
    endtask

    task automatic test_rst_priority();
        rst = 1'b1;
        eaten = 1'b1;
        tick();
        rst = 1'b0;
        eaten = 1'b0;
        n_checks++; if (busy !== 1'b0 || apple_x !== 5'd15 || apple_y !== 5'd15) begin n_fail++; $display("FAIL rst_priority busy=%b apple=(%0d,%0d) want 0 (15,15)", busy, apple_x, apple_y); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_priority_after busy=%b want 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            body_x[i] = 5'd0;
            body_y[i] = 5'd20;
        end
        body_x[0] = 5'd1; body_y[0] = 5'd1;
        body_x[1] = 5'd2; body_y[1] = 5'd1;
        body_x[2] = 5'd3; body_y[2] = 5'd1;

        test_reset();
        test_spawn_basic();
        test_fold();
        test_zero_length();
        test_retry();
        test_force_place();
        test_reset_mid_scan();
        test_eaten_while_busy();
        test_rst_priority();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
